instruction_fetch_unit: RTL and testbench

Fetch-stage controller that drives `pc_out` into `InstructionMemory` and consumes `output_instr`. The memory has a registered read: the word for the address sampled at edge k is valid during cycle k+1. The block tracks that in-flight request and captures the returned instruction into the IF/ID pipeline register. It handles stall via a one-entry hold buffer and applies branch/jump redirects with wrong-path squash.

---
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage controller: drives the instruction memory address, tracks the
// in-flight registered read, and fills IF/ID with stall hold and redirect squash.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      pc_out,
   input  logic [31:0]      imem_instr,
   output logic [31:0]      if_id_instr,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_pc_plus4,
   output logic             if_id_valid,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic {RUN, HOLD} state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       req_pc_q, req_pc_d;
   logic              req_valid_q, req_valid_d;
   logic [31:0]       hold_instr_q, hold_instr_d;
   logic [31:0]       hold_pc_q, hold_pc_d;
   logic              hold_valid_q, hold_valid_d;
   logic [31:0]       id_instr_q, id_instr_d;
   logic [31:0]       id_pc_q, id_pc_d;
   logic [31:0]       id_pc4_q, id_pc4_d;
   logic              id_valid_q, id_valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       tgt;

   // Word-align the redirect target
   assign tgt = redirect_pc & ~32'd3;

   // State register bank; reset discards any in-flight request and hold entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         req_valid_q  <= 1'b0;
         hold_instr_q <= NOP_INSTR;
         hold_pc_q    <= '0;
         hold_valid_q <= 1'b0;
         id_instr_q   <= NOP_INSTR;
         id_pc_q      <= '0;
         id_pc4_q     <= '0;
         id_valid_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         req_valid_q  <= req_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         hold_valid_q <= hold_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pc4_q     <= id_pc4_d;
         id_valid_q   <= id_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state: redirect squashes everything, else RUN/HOLD stall handling
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      req_valid_d  = req_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      hold_valid_d = hold_valid_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc4_d     = id_pc4_q;
      id_valid_d   = id_valid_q;
      cnt_d        = cnt_q;
      if (redirect) begin
         pc_d         = tgt;
         id_valid_d   = 1'b0;
         id_instr_d   = NOP_INSTR;
         req_valid_d  = 1'b0;
         hold_valid_d = 1'b0;
         state_d      = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               req_pc_d    = pc_q;
               req_valid_d = 1'b1;
               if (stall) begin
                  hold_instr_d = imem_instr;
                  hold_pc_d    = req_pc_q;
                  hold_valid_d = req_valid_q;
                  state_d      = HOLD;
               end else begin
                  id_instr_d = req_valid_q ? imem_instr : NOP_INSTR;
                  id_pc_d    = req_pc_q;
                  id_pc4_d   = req_pc_q + 32'd4;
                  id_valid_d = req_valid_q;
                  pc_d       = pc_q + 32'd4;
                  if (req_valid_q) cnt_d = cnt_q + CNT_W'(1);
               end
            end
            HOLD: begin
               if (!stall) begin
                  id_instr_d   = hold_valid_q ? hold_instr_q : NOP_INSTR;
                  id_pc_d      = hold_pc_q;
                  id_pc4_d     = hold_pc_q + 32'd4;
                  id_valid_d   = hold_valid_q;
                  pc_d         = pc_q + 32'd4;
                  hold_valid_d = 1'b0;
                  state_d      = RUN;
                  if (hold_valid_q) cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign pc_out         = pc_q;
   assign if_id_instr    = id_instr_q;
   assign if_id_pc       = id_pc_q;
   assign if_id_pc_plus4 = id_pc4_q;
   assign if_id_valid    = id_valid_q;
   assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: registered-read memory model and
// a per-edge expectation queue checked after each rising edge.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc_out;
   logic [31:0] imem_instr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] po;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] exp_cnt = '0;

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .pc_out         (pc_out),
      .imem_instr     (imem_instr),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_instr <= 32'hA000_0000 | pc_out;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic rd, input logic [31:0] tg,
                      input logic v, input logic [31:0] pc,
                      input logic [31:0] po, input logic inc);
      exp_t e;
      exp_t g;
      @(negedge clk);
      stall       = st;
      redirect    = rd;
      redirect_pc = tg;
      if (inc) exp_cnt = exp_cnt + 32'd1;
      e.v = v; e.pc = pc; e.po = po; e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("valid", {31'd0, if_id_valid}, {31'd0, g.v});
      chk("pc_out", pc_out, g.po);
      chk("count", fetch_count, g.cnt);
      if (g.v) begin
         chk("instr", if_id_instr, 32'hA000_0000 | g.pc);
         chk("pc", if_id_pc, g.pc);
         chk("pc4", if_id_pc_plus4, g.pc + 32'd4);
      end else begin
         chk("nop", if_id_instr, NOP);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_po"}, pc_out, 32'h0);
      chk({tag, "_v"}, {31'd0, if_id_valid}, 32'd0);
      chk({tag, "_in"}, if_id_instr, NOP);
      chk({tag, "_pc"}, if_id_pc, 32'h0);
      chk({tag, "_p4"}, if_id_pc_plus4, 32'h0);
      chk({tag, "_cnt"}, fetch_count, 32'h0);
   endtask

   initial begin
      #12;
      chk_reset("rst");
      @(posedge clk);
      #2 rst_n = 1'b1;
      // sequential fetch from reset
      cyc(0, 0, 0, 0, 0,    32'h04, 0);
      cyc(0, 0, 0, 1, 32'h00, 32'h08, 1);
      cyc(0, 0, 0, 1, 32'h04, 32'h0C, 1);
      cyc(0, 0, 0, 1, 32'h08, 32'h10, 1);
      // three-cycle stall then release
      cyc(1, 0, 0, 1, 32'h08, 32'h10, 0);
      cyc(1, 0, 0, 1, 32'h08, 32'h10, 0);
      cyc(1, 0, 0, 1, 32'h08, 32'h10, 0);
      cyc(0, 0, 0, 1, 32'h0C, 32'h14, 1);
      cyc(0, 0, 0, 1, 32'h10, 32'h18, 1);
      cyc(0, 0, 0, 1, 32'h14, 32'h1C, 1);
      // redirect while running
      cyc(0, 1, 32'h40, 0, 0, 32'h40, 0);
      cyc(0, 0, 0,      0, 0, 32'h44, 0);
      cyc(0, 0, 0, 1, 32'h40, 32'h48, 1);
      cyc(0, 0, 0, 1, 32'h44, 32'h4C, 1);
      // redirect + stall together from RUN, unaligned target
      cyc(1, 1, 32'h83, 0, 0, 32'h80, 0);
      cyc(0, 0, 0,      0, 0, 32'h84, 0);
      cyc(0, 0, 0, 1, 32'h80, 32'h88, 1);
      // redirect + stall from HOLD
      cyc(1, 0, 0,      1, 32'h80, 32'h88, 0);
      cyc(1, 1, 32'h43, 0, 0, 32'h40, 0);
      cyc(0, 0, 0,      0, 0, 32'h44, 0);
      cyc(0, 0, 0, 1, 32'h40, 32'h48, 1);
      cyc(0, 0, 0, 1, 32'h44, 32'h4C, 1);
      // asynchronous reset in the middle of HOLD
      cyc(1, 0, 0, 1, 32'h44, 32'h4C, 0);
      #2 rst_n = 1'b0;
      #1 chk_reset("arst");
      exp_cnt = '0;
      stall = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0,    32'h04, 0);
      cyc(0, 0, 0, 1, 32'h00, 32'h08, 1);
      cyc(0, 0, 0, 1, 32'h04, 32'h0C, 1);
      // redirect to the top word: address wraps
      cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0);
      cyc(0, 0, 0, 0, 0, 32'h0000_0000, 0);
      cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h04, 1);
      cyc(0, 0, 0, 1, 32'h0000_0000, 32'h08, 1);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
